// File: rtl/uart_boot_loader_pkg.sv
// Shared encodings for the UART boot loader: FSM states, sticky error codes
// and the default frame start marker.
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        WAIT_SYNC = 3'd0,
        LEN_LO    = 3'd1,
        LEN_HI    = 3'd2,
        PAYLOAD   = 3'd3,
        CHECK     = 3'd4,
        RUN       = 3'd5
    } boot_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_FRAME   = 2'd3
    } boot_err_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Boot loader bus: UART byte stream in, instruction-memory writes and CPU
// control/status out.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_err;
    logic              load_req;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic [1:0]        error_code;

    modport slave (
        input  rx_valid, rx_data, rx_err, load_req,
        output imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, error_code
    );

    modport master (
        output rx_valid, rx_data, rx_err, load_req,
        input  imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, error_code
    );
endinterface

// File: rtl/uart_boot_loader_word_packer.sv
// Little-endian byte-to-word assembler: the first byte of a word lands in
// [7:0]; word_vld_o pulses the cycle after the fourth byte.
module boot_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  idx_o,
    output logic        word_vld_o,
    output logic [31:0] word_o
);
    logic [1:0]  cnt_q;
    logic        wvld_q;
    logic [31:0] word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wvld_q <= 1'b0;
            word_q <= '0;
        end else begin
            wvld_q <= 1'b0;
            if (clr_i) begin
                cnt_q  <= '0;
                word_q <= '0;
            end else if (byte_vld_i) begin
                word_q <= {byte_i, word_q[31:8]};
                cnt_q  <= cnt_q + 2'd1;
                wvld_q <= (cnt_q == 2'd3);
            end
        end
    end

    assign idx_o      = cnt_q;
    assign word_vld_o = wvld_q;
    assign word_o     = word_q;
endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: holds the CPU in reset, receives a framed image over UART,
// writes it into instruction memory, verifies an XOR checksum, releases the CPU.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int         ADDR_W      = 10,
    parameter int         TIMEOUT_CYC = 200000,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    uart_boot_loader_if.slave bus
);
    localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

    boot_state_t       state_q, state_d;
    boot_err_t         err_q, err_d;
    logic [7:0]        csum_q, csum_d;
    logic [15:0]       len_q, len_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, done_q, cpu_rst_q;

    logic        pk_clr, pk_vld, pk_wvld, in_frame, last_word;
    logic [1:0]  pk_idx;
    logic [31:0] pk_word;
    logic [16:0] len_new;

    boot_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (pk_clr),
        .byte_vld_i (pk_vld),
        .byte_i     (bus.rx_data),
        .idx_o      (pk_idx),
        .word_vld_o (pk_wvld),
        .word_o     (pk_word)
    );

    assign in_frame  = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == PAYLOAD) || (state_q == CHECK);
    // addr_q still holds the current word index when its 4th byte arrives
    assign last_word = (17'(addr_q) + 17'd1) == {1'b0, len_q};
    assign len_new   = {1'b0, bus.rx_data, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        csum_d  = csum_q;
        len_d   = len_q;
        addr_d  = addr_q;
        pk_clr  = 1'b0;
        pk_vld  = 1'b0;
        tmo_d   = '0;
        if (in_frame && !bus.rx_valid) tmo_d = tmo_q + TW'(1);
        if (pk_wvld) addr_d = addr_q + ADDR_W'(1);

        if (in_frame && bus.rx_err) begin
            state_d = WAIT_SYNC;
            err_d   = ERR_FRAME;
        end else if (in_frame && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = WAIT_SYNC;
            err_d   = ERR_TIMEOUT;
        end else begin
            case (state_q)
                WAIT_SYNC: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                    state_d = LEN_LO;
                    err_d   = ERR_NONE;
                    csum_d  = '0;
                    addr_d  = '0;
                    pk_clr  = 1'b1;
                end
                LEN_LO: if (bus.rx_valid) begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = LEN_HI;
                end
                LEN_HI: if (bus.rx_valid) begin
                    len_d[15:8] = bus.rx_data;
                    if (len_new > MAX_LEN) begin
                        state_d = WAIT_SYNC;
                        err_d   = ERR_FRAME;
                    end else if (len_new == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: if (bus.rx_valid) begin
                    csum_d = csum_q ^ bus.rx_data;
                    pk_vld = 1'b1;
                    if (pk_idx == 2'd3 && last_word) state_d = CHECK;
                end
                CHECK: if (bus.rx_valid) begin
                    if (bus.rx_data == csum_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = WAIT_SYNC;
                        err_d   = ERR_CSUM;
                    end
                end
                RUN: if (bus.load_req) state_d = WAIT_SYNC;
                default: state_d = WAIT_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_SYNC;
            err_q     <= ERR_NONE;
            csum_q    <= '0;
            len_q     <= '0;
            tmo_q     <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            csum_q    <= csum_d;
            len_q     <= len_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            busy_q    <= (state_d == LEN_LO) || (state_d == LEN_HI) ||
                         (state_d == PAYLOAD) || (state_d == CHECK);
            done_q    <= (state_d == RUN);
            cpu_rst_q <= (state_d != RUN);
        end
    end

    assign bus.imem_we    = pk_wvld;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = pk_word;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error_code = err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: nominal load, checksum/timeout/framing
// errors, reload, mid-frame reset and zero-length image.
module tb_uart_boot_loader;
    localparam int AW  = 10;
    localparam int TMO = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_boot_loader_if #(.ADDR_W(AW)) bus ();

    uart_boot_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic        we_prev = 1'b0;
    int          long_we = 0;
    logic [7:0]  fq[$];

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wa.push_back(32'(bus.imem_addr));
            wd.push_back(bus.imem_wdata);
        end
        if (bus.imem_we && we_prev) long_we++;
        we_prev = bus.imem_we;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_all();
        while (fq.size() > 0) send_byte(fq.pop_front());
    endtask

    task automatic pulse_load();
        @(posedge clk); #1;
        bus.load_req = 1'b1;
        @(posedge clk); #1;
        bus.load_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".cpu_rst"}, 32'(bus.cpu_rst), 32'd1);
        chk({tag, ".we"},      32'(bus.imem_we), 32'd0);
        chk({tag, ".addr"},    32'(bus.imem_addr), 32'd0);
        chk({tag, ".wdata"},   bus.imem_wdata, 32'd0);
        chk({tag, ".busy"},    32'(bus.busy), 32'd0);
        chk({tag, ".done"},    32'(bus.done), 32'd0);
        chk({tag, ".err"},     32'(bus.error_code), 32'd0);
    endtask

    // Payload 13 00 00 00 93 00 10 00: XOR = 0x13^0x93^0x10 = 0x90
    task automatic load_nominal_body();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_all();
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_err   = 1'b0;
        bus.load_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 1'b0;

        // Nominal load
        wa.delete(); wd.delete();
        load_nominal_body();
        chk("nom.busy_pre", 32'(bus.busy), 32'd1);
        chk("nom.cpu_rst_pre", 32'(bus.cpu_rst), 32'd1);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1; bus.rx_data = 8'h90;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        chk("nom.cpu_rst_n1", 32'(bus.cpu_rst), 32'd0);
        chk("nom.done", 32'(bus.done), 32'd1);
        chk("nom.err", 32'(bus.error_code), 32'd0);
        chk("nom.busy", 32'(bus.busy), 32'd0);
        chk("nom.nwr", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("nom.a0", wa[0], 32'd0);
            chk("nom.d0", wd[0], 32'h0000_0013);
            chk("nom.a1", wa[1], 32'd1);
            chk("nom.d1", wd[1], 32'h0010_0093);
        end

        // RUN ignores bytes and rx_err
        send_byte(8'hA5);
        @(posedge clk); #1; bus.rx_err = 1'b1;
        @(posedge clk); #1; bus.rx_err = 1'b0;
        chk("run.hold_done", 32'(bus.done), 32'd1);
        chk("run.hold_err", 32'(bus.error_code), 32'd0);

        // load_req with simultaneous A5: byte dropped
        @(posedge clk); #1;
        bus.load_req = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'hA5;
        @(posedge clk); #1;
        bus.load_req = 1'b0; bus.rx_valid = 1'b0;
        chk("rld.cpu_rst", 32'(bus.cpu_rst), 32'd1);
        chk("rld.done", 32'(bus.done), 32'd0);
        chk("rld.busy", 32'(bus.busy), 32'd0);
        send_byte(8'h02);
        chk("rld.dropped", 32'(bus.busy), 32'd0);

        // Bad checksum
        wa.delete(); wd.delete();
        load_nominal_body();
        send_byte(8'h91);
        chk("csum.nwr", 32'(wa.size()), 32'd2);
        chk("csum.cpu_rst", 32'(bus.cpu_rst), 32'd1);
        chk("csum.done", 32'(bus.done), 32'd0);
        chk("csum.busy", 32'(bus.busy), 32'd0);
        chk("csum.err", 32'(bus.error_code), 32'd1);

        // Timeout, then recovery
        wa.delete(); wd.delete();
        fq = '{8'hA5, 8'h01, 8'h00, 8'h13};
        send_all();
        chk("tmo.busy_mid", 32'(bus.busy), 32'd1);
        repeat (TMO + 5) @(posedge clk);
        #1;
        chk("tmo.err", 32'(bus.error_code), 32'd2);
        chk("tmo.busy", 32'(bus.busy), 32'd0);
        chk("tmo.nwr", 32'(wa.size()), 32'd0);
        load_nominal_body();
        send_byte(8'h90);
        chk("tmo.recover_done", 32'(bus.done), 32'd1);
        chk("tmo.recover_err", 32'(bus.error_code), 32'd0);
        pulse_load();
        chk("tmo.rearm", 32'(bus.cpu_rst), 32'd1);

        // Oversize: LEN = 1025
        wa.delete(); wd.delete();
        fq = '{8'hA5, 8'h01, 8'h04};
        send_all();
        chk("ovr.err", 32'(bus.error_code), 32'd3);
        chk("ovr.busy", 32'(bus.busy), 32'd0);
        repeat (3) @(posedge clk);
        chk("ovr.nwr", 32'(wa.size()), 32'd0);

        // Framing error during payload
        fq = '{8'hA5, 8'h01, 8'h00, 8'h13};
        send_all();
        chk("frm.err_cleared", 32'(bus.error_code), 32'd0);
        @(posedge clk); #1; bus.rx_err = 1'b1;
        @(posedge clk); #1; bus.rx_err = 1'b0;
        chk("frm.err", 32'(bus.error_code), 32'd3);
        chk("frm.busy", 32'(bus.busy), 32'd0);
        chk("frm.nwr", 32'(wa.size()), 32'd0);

        // Reset after 6 payload bytes
        wa.delete(); wd.delete();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        send_all();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check_reset_vals("mrst");
        fq = '{8'h10, 8'h00, 8'h90};
        send_all();
        chk("mrst.nwr", 32'(wa.size()), 32'd1);
        chk("mrst.busy", 32'(bus.busy), 32'd0);

        // Zero length
        wa.delete(); wd.delete();
        fq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_all();
        chk("zero.nwr", 32'(wa.size()), 32'd0);
        chk("zero.cpu_rst", 32'(bus.cpu_rst), 32'd0);
        chk("zero.done", 32'(bus.done), 32'd1);

        chk("we.width", 32'(long_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
